// File: rtl/bc_to_num_if.sv
// Module stream in, decoded digit slot out, for the Code 128 symbol receiver.
interface bc_to_num_if;
    logic       mod_valid;
    logic       mod_bit;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_ready;
    logic       sym_err;
    logic       overrun;
    logic       busy;

    // Sampler/consumer side: drives modules and ready, observes the slot.
    modport master (
        output mod_valid,
        output mod_bit,
        output digit_ready,
        input  digit,
        input  digit_valid,
        input  sym_err,
        input  overrun,
        input  busy
    );

    // Receiver side.
    modport slave (
        input  mod_valid,
        input  mod_bit,
        input  digit_ready,
        output digit,
        output digit_valid,
        output sym_err,
        output overrun,
        output busy
    );
endinterface

// File: rtl/bc_to_num.sv
// Serial Code 128 symbol receiver: frames 11-module symbols, decodes digits 0-9
// into a one-entry valid/ready slot, flags bad patterns, timeouts and overruns.
module bc_to_num #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    bc_to_num_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    // Counter is sized to hold TIMEOUT itself; a disabled timeout keeps a 1-bit stub.
    localparam int unsigned   TW        = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_ONE   = TW'(1);
    localparam logic [3:0]    CNT_ONE   = 4'd1;
    localparam logic [3:0]    CNT_LAST  = 4'd10;

    // Exact-match lookup; bit 4 of the result is the hit flag, bits 3:0 the digit.
    function automatic logic [4:0] decode_sym(input logic [10:0] word);
        logic [4:0] res;
        res = 5'b0_0000;
        case (word)
            11'b11011001100: res = {1'b1, 4'd0};
            11'b11001101100: res = {1'b1, 4'd1};
            11'b11001100110: res = {1'b1, 4'd2};
            11'b10010011000: res = {1'b1, 4'd3};
            11'b10010001100: res = {1'b1, 4'd4};
            11'b10001001100: res = {1'b1, 4'd5};
            11'b10011001000: res = {1'b1, 4'd6};
            11'b10011000100: res = {1'b1, 4'd7};
            11'b10001100100: res = {1'b1, 4'd8};
            11'b11001001000: res = {1'b1, 4'd9};
            default:         res = 5'b0_0000;
        endcase
        return res;
    endfunction

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [9:0]    shreg_q, shreg_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    digit_q, digit_d;
    logic          digit_valid_q, digit_valid_d;
    logic          sym_err_q, sym_err_d;
    logic          overrun_q, overrun_d;
    logic          busy_q, busy_d;

    logic [10:0]   word_s;
    logic [TW-1:0] tmo_inc_s;
    logic          sym_done_s;
    logic          tmo_hit_s;
    logic [4:0]    dec_s;
    logic          accept_s;

    // State register and all output flops, synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            shreg_q       <= 10'd0;
            tmo_q         <= '0;
            digit_q       <= 4'd0;
            digit_valid_q <= 1'b0;
            sym_err_q     <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            tmo_q         <= tmo_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            sym_err_q     <= sym_err_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state: symbol framing, module shifting and inter-strobe timeout.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        tmo_d      = tmo_q;
        sym_done_s = 1'b0;
        tmo_hit_s  = 1'b0;
        word_s     = {shreg_q, bus.mod_bit};
        tmo_inc_s  = tmo_q + TMO_ONE;
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                // A leading bar starts a symbol; spaces are quiet zone.
                if (bus.mod_valid && bus.mod_bit) begin
                    state_d = ST_RECV;
                    cnt_d   = CNT_ONE;
                    shreg_d = 10'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (bus.mod_valid) begin
                    tmo_d   = '0;
                    shreg_d = word_s[9:0];
                    if (cnt_q == CNT_LAST) begin
                        sym_done_s = 1'b1;
                        state_d    = ST_IDLE;
                        cnt_d      = 4'd0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if ((TIMEOUT != 32'd0) && (tmo_inc_s == TMO_LIMIT)) begin
                    tmo_hit_s = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_d     = 4'd0;
                    shreg_d   = 10'd0;
                    tmo_d     = '0;
                end else begin
                    tmo_d = tmo_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                shreg_d = 10'd0;
                tmo_d   = '0;
            end
        endcase
    end

    // Outputs: decode on the 11th module and manage the single-entry digit slot.
    always_comb begin
        dec_s         = decode_sym(word_s);
        accept_s      = digit_valid_q && bus.digit_ready;
        digit_d       = digit_q;
        digit_valid_d = digit_valid_q;
        sym_err_d     = 1'b0;
        overrun_d     = 1'b0;
        if (sym_done_s && dec_s[4]) begin
            // Loading over an accepted digit keeps valid high with no bubble.
            if (!digit_valid_q || bus.digit_ready) begin
                digit_d       = dec_s[3:0];
                digit_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            if (accept_s) begin
                digit_valid_d = 1'b0;
            end else begin
                digit_valid_d = digit_valid_q;
            end
            if (sym_done_s || tmo_hit_s) begin
                sym_err_d = 1'b1;
            end else begin
                sym_err_d = 1'b0;
            end
        end
        busy_d = (state_d == ST_RECV);
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.sym_err     = sym_err_q;
    assign bus.overrun     = overrun_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_bc_to_num.sv
// Self-checking bench for bc_to_num with a queue-based reference model.
module tb_bc_to_num;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst;
    bc_to_num_if bus();

    bc_to_num #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic rs;
        logic v;
        logic b;
        logic r;
    } stim_t;

    stim_t stim[$];
    int    n_checks = 0;
    int    n_errs   = 0;
    int    cyc      = 0;

    logic [10:0] codes [10] = '{
        11'b11011001100, 11'b11001101100, 11'b11001100110, 11'b10010011000,
        11'b10010001100, 11'b10001001100, 11'b10011001000, 11'b10011000100,
        11'b10001100100, 11'b11001001000
    };

    // Reference model state
    int         mq[$];
    int         m_gap   = 0;
    logic [3:0] m_digit = 4'd0;
    logic       m_valid = 1'b0;
    logic       m_err   = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_busy  = 1'b0;

    function automatic int lookup(input logic [10:0] w);
        for (int i = 0; i < 10; i++) begin
            if (codes[i] == w) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input stim_t s);
        logic [10:0] word;
        int          match;
        logic        done;
        logic        e_err;
        logic        e_ovr;
        word  = 11'd0;
        match = -1;
        done  = 1'b0;
        e_err = 1'b0;
        e_ovr = 1'b0;
        if (s.rs) begin
            mq.delete();
            m_gap   = 0;
            m_digit = 4'd0;
            m_valid = 1'b0;
        end else begin
            if (s.v) begin
                if (mq.size() > 0 || s.b) mq.push_back(s.b ? 1 : 0);
                m_gap = 0;
                if (mq.size() == 11) begin
                    for (int i = 0; i < 11; i++) word = (word << 1) | 11'(mq[i]);
                    mq.delete();
                    done  = 1'b1;
                    match = lookup(word);
                    if (match < 0) e_err = 1'b1;
                end
            end else if (mq.size() > 0) begin
                m_gap++;
                if (TIMEOUT > 0 && m_gap == TIMEOUT) begin
                    e_err = 1'b1;
                    mq.delete();
                    m_gap = 0;
                end
            end
            if (done && match >= 0) begin
                if (!m_valid || s.r) begin
                    m_digit = 4'(match);
                    m_valid = 1'b1;
                end else begin
                    e_ovr = 1'b1;
                end
            end else if (m_valid && s.r) begin
                m_valid = 1'b0;
            end
        end
        m_err  = e_err;
        m_ovr  = e_ovr;
        m_busy = (mq.size() > 0);
    endtask

    task automatic drive(input stim_t s);
        @(negedge clk);
        rst             = s.rs;
        bus.mod_valid   = s.v;
        bus.mod_bit     = s.b;
        bus.digit_ready = s.r;
        @(posedge clk);
        model_step(s);
        cyc++;
        #1;
    endtask

    function automatic logic [7:0] obs();
        return {bus.digit, bus.digit_valid, bus.sym_err, bus.overrun, bus.busy};
    endfunction

    function automatic logic [7:0] exp_v();
        return {m_digit, m_valid, m_err, m_ovr, m_busy};
    endfunction

    task automatic add(input logic rs, input logic v, input logic b, input logic r);
        stim_t s;
        s.rs = rs;
        s.v  = v;
        s.b  = b;
        s.r  = r;
        stim.push_back(s);
    endtask

    task automatic add_idle(input int n, input logic r);
        repeat (n) add(1'b0, 1'b0, 1'b0, r);
    endtask

    // Strobes the 11 modules MSB first, with gap idle cycles between strobes.
    task automatic add_sym(input logic [10:0] pat, input int gap, input logic r);
        for (int i = 10; i >= 0; i--) begin
            add(1'b0, 1'b1, pat[i], r);
            if (i > 0) add_idle(gap, r);
        end
    endtask

    task automatic test_reset;
        add(1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_checks++;
            if (obs() !== exp_v()) begin
                n_errs++;
                $display("FAIL reset_cycle cyc=%0d got=%h want=%h", cyc, obs(), exp_v());
            end
        end
        n_checks++;
        if (obs() !== 8'h00) begin
            n_errs++;
            $display("FAIL reset_outputs got=%h want=00", obs());
        end
    endtask

    task automatic test_digit0;
        add_sym(11'b11011001100, 0, 1'b1);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_checks++;
            if (obs() !== exp_v()) begin
                n_errs++;
                $display("FAIL digit0_cycle cyc=%0d got=%h want=%h", cyc, obs(), exp_v());
            end
        end
        n_checks++;
        if (bus.digit !== 4'd0 || bus.digit_valid !== 1'b1 || bus.sym_err !== 1'b0) begin
            n_errs++;
            $display("FAIL digit0_result got=%h want digit=0 valid=1 err=0", obs());
        end
    endtask

    task automatic test_quiet_gap;
        add_idle(2, 1'b1);
        repeat (3) add(1'b0, 1'b1, 1'b0, 1'b0);
        add_sym(11'b11001001000, 2, 1'b0);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_checks++;
            if (obs() !== exp_v()) begin
                n_errs++;
                $display("FAIL quiet_cycle cyc=%0d got=%h want=%h", cyc, obs(), exp_v());
            end
        end
        n_checks++;
        if (bus.digit !== 4'd9 || bus.digit_valid !== 1'b1) begin
            n_errs++;
            $display("FAIL quiet_digit9 got=%h want digit=9 valid=1", obs());
        end
    endtask

    task automatic test_bad_pattern;
        add_idle(2, 1'b1);
        add_sym(11'b11111111110, 0, 1'b1);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_checks++;
            if (obs() !== exp_v()) begin
                n_errs++;
                $display("FAIL bad_cycle cyc=%0d got=%h want=%h", cyc, obs(), exp_v());
            end
        end
        n_checks++;
        if (bus.sym_err !== 1'b1 || bus.digit_valid !== 1'b0) begin
            n_errs++;
            $display("FAIL bad_err_pulse got=%h want err=1 valid=0", obs());
        end
        add_idle(1, 1'b1);
        drive(stim.pop_front());
        n_checks++;
        if (bus.sym_err !== 1'b0) begin
            n_errs++;
            $display("FAIL bad_err_width got=%b want=0", bus.sym_err);
        end
        add_sym(11'b10010011000, 0, 1'b1);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_checks++;
            if (obs() !== exp_v()) begin
                n_errs++;
                $display("FAIL bad_next_cycle cyc=%0d got=%h want=%h", cyc, obs(), exp_v());
            end
        end
        n_checks++;
        if (bus.digit !== 4'd3 || bus.digit_valid !== 1'b1) begin
            n_errs++;
            $display("FAIL bad_next_digit3 got=%h want digit=3 valid=1", obs());
        end
    endtask

    task automatic test_overrun;
        add_idle(2, 1'b1);
        add_sym(11'b10001001100, 0, 1'b0);
        add_sym(11'b10011000100, 0, 1'b0);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_checks++;
            if (obs() !== exp_v()) begin
                n_errs++;
                $display("FAIL overrun_cycle cyc=%0d got=%h want=%h", cyc, obs(), exp_v());
            end
        end
        n_checks++;
        if (bus.overrun !== 1'b1 || bus.digit !== 4'd5 || bus.digit_valid !== 1'b1 || bus.sym_err !== 1'b0) begin
            n_errs++;
            $display("FAIL overrun_pulse got=%h want digit=5 valid=1 ovr=1 err=0", obs());
        end
        add_idle(1, 1'b1);
        drive(stim.pop_front());
        n_checks++;
        if (bus.digit_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.digit !== 4'd5) begin
            n_errs++;
            $display("FAIL overrun_drain got=%h want digit=5 valid=0 ovr=0", obs());
        end
    endtask

    task automatic test_timeout;
        logic [4:0] head;
        head = 5'b11011;
        add_idle(2, 1'b1);
        for (int i = 4; i >= 0; i--) add(1'b0, 1'b1, head[i], 1'b1);
        add_idle(TIMEOUT - 1, 1'b1);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_checks++;
            if (obs() !== exp_v()) begin
                n_errs++;
                $display("FAIL timeout_cycle cyc=%0d got=%h want=%h", cyc, obs(), exp_v());
            end
        end
        n_checks++;
        if (bus.sym_err !== 1'b0 || bus.busy !== 1'b1) begin
            n_errs++;
            $display("FAIL timeout_early got=%h want err=0 busy=1", obs());
        end
        add_idle(1, 1'b1);
        drive(stim.pop_front());
        n_checks++;
        if (bus.sym_err !== 1'b1 || bus.busy !== 1'b0) begin
            n_errs++;
            $display("FAIL timeout_fire got=%h want err=1 busy=0", obs());
        end
        add_idle(1, 1'b1);
        add_sym(11'b11001100110, 0, 1'b1);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_checks++;
            if (obs() !== exp_v()) begin
                n_errs++;
                $display("FAIL timeout_next_cycle cyc=%0d got=%h want=%h", cyc, obs(), exp_v());
            end
        end
        n_checks++;
        if (bus.digit !== 4'd2 || bus.digit_valid !== 1'b1) begin
            n_errs++;
            $display("FAIL timeout_digit2 got=%h want digit=2 valid=1", obs());
        end
    endtask

    task automatic test_reset_mid;
        logic [10:0] p6;
        p6 = 11'b10011001000;
        add_idle(2, 1'b1);
        for (int i = 10; i >= 5; i--) add(1'b0, 1'b1, p6[i], 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_checks++;
            if (obs() !== exp_v()) begin
                n_errs++;
                $display("FAIL rstmid_cycle cyc=%0d got=%h want=%h", cyc, obs(), exp_v());
            end
        end
        n_checks++;
        if (obs() !== 8'h00) begin
            n_errs++;
            $display("FAIL rstmid_partial got=%h want=00", obs());
        end
        add_sym(11'b10010001100, 0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_checks++;
            if (obs() !== exp_v()) begin
                n_errs++;
                $display("FAIL rstmid_pending_cycle cyc=%0d got=%h want=%h", cyc, obs(), exp_v());
            end
        end
        n_checks++;
        if (obs() !== 8'h00) begin
            n_errs++;
            $display("FAIL rstmid_pending got=%h want=00", obs());
        end
        add_sym(p6, 0, 1'b0);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_checks++;
            if (obs() !== exp_v()) begin
                n_errs++;
                $display("FAIL rstmid_next_cycle cyc=%0d got=%h want=%h", cyc, obs(), exp_v());
            end
        end
        n_checks++;
        if (bus.digit !== 4'd6 || bus.digit_valid !== 1'b1) begin
            n_errs++;
            $display("FAIL rstmid_digit6 got=%h want digit=6 valid=1", obs());
        end
    endtask

    task automatic test_back_to_back;
        add_idle(2, 1'b1);
        add_sym(11'b10001100100, 0, 1'b0);
        add_sym(11'b11001101100, 0, 1'b0);
        stim[stim.size() - 1].r = 1'b1;
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_checks++;
            if (obs() !== exp_v()) begin
                n_errs++;
                $display("FAIL b2b_cycle cyc=%0d got=%h want=%h", cyc, obs(), exp_v());
            end
        end
        n_checks++;
        if (bus.digit !== 4'd1 || bus.digit_valid !== 1'b1 || bus.overrun !== 1'b0) begin
            n_errs++;
            $display("FAIL b2b_no_bubble got=%h want digit=1 valid=1 ovr=0", obs());
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 120; k++) begin
            int          sel;
            int          mode;
            logic [10:0] pat;
            logic [9:0]  tail;
            sel  = $urandom_range(0, 9);
            mode = $urandom_range(0, 9);
            tail = 10'($urandom);
            pat  = (mode < 2) ? {1'b1, tail} : codes[sel];
            repeat ($urandom_range(0, 2)) add(1'b0, 1'b1, 1'b0, 1'b0);
            if (mode == 9) begin
                for (int i = 10; i >= 6; i--) add(1'b0, 1'b1, pat[i], 1'b0);
                add_idle($urandom_range(TIMEOUT - 2, TIMEOUT + 3), 1'b0);
            end else begin
                add_sym(pat, $urandom_range(0, 2), 1'b0);
            end
        end
        for (int i = 0; i < stim.size(); i++) stim[i].r = 1'($urandom_range(0, 1));
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_checks++;
            if (obs() !== exp_v()) begin
                n_errs++;
                $display("FAIL random_cycle cyc=%0d got=%h want=%h", cyc, obs(), exp_v());
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.mod_valid   = 1'b0;
        bus.mod_bit     = 1'b0;
        bus.digit_ready = 1'b0;
        test_reset();
        test_digit0();
        test_quiet_gap();
        test_bad_pattern();
        test_overrun();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
